// File: rtl/switch_game_round_ctrl.sv
// Round sequencer for the switch game: game FSM, round/break countdowns, score, rounds and lives.
// Optional build macro SWITCH_GAME_SPEEDUP_EN shortens each round as the points exponent grows.
module switch_game_round_ctrl #(
    parameter int unsigned ROUND_SECS     = 15,
    parameter int unsigned BREAK_SECS     = 5,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned MIN_ROUND_SECS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_1hz,
    input  logic        start,
    input  logic        check_valid,
    input  logic        is_correct,
    output logic        choose_flag,
    output logic [2:0]  state,
    output logic [5:0]  time_left,
    output logic [7:0]  round_cnt,
    output logic [13:0] score,
    output logic [1:0]  lives_left,
    output logic        round_active,
    output logic        game_over
);

    localparam int unsigned TIME_W  = 6;
    localparam int unsigned ROUND_W = 8;
    localparam int unsigned SCORE_W = 14;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned EXP_W   = 3;
    localparam int unsigned MOD_W   = 3;
    localparam int unsigned PTS_W   = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(9999);
    localparam logic [ROUND_W-1:0] ROUND_MAX  = ROUND_W'(255);
    localparam logic [EXP_W-1:0]   EXP_MAX    = EXP_W'(6);
    localparam logic [MOD_W-1:0]   MOD_LAST   = MOD_W'(4);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [TIME_W-1:0]  BREAK_LEN  = TIME_W'(BREAK_SECS);
    localparam logic [TIME_W-1:0]  ROUND_LEN  = TIME_W'(ROUND_SECS);
    // Floor never exceeds the nominal round length, so an unshortened round is always ROUND_SECS.
    localparam logic [TIME_W-1:0]  FLOOR_LEN  =
        TIME_W'((MIN_ROUND_SECS < ROUND_SECS) ? MIN_ROUND_SECS : ROUND_SECS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROMPT = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4,
        ST_BREAK  = 3'd5,
        ST_OVER   = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic                 choose_q, choose_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [MOD_W-1:0]     pass_mod_q, pass_mod_d;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic                 start_q, start_d;

    logic                 start_rise;
    logic [EXP_W-1:0]     speed_e;
    logic [TIME_W-1:0]    round_len;
    logic [PTS_W-1:0]     points;
    logic [SCORE_W:0]     score_sum;

    assign start_rise = start & ~start_q;

`ifdef SWITCH_GAME_SPEEDUP_EN
    assign speed_e = exp_q;
`else
    assign speed_e = '0;
`endif

    // Round length = ROUND_SECS - e, clamped at the floor.
    always_comb begin
        if ((TIME_W+1)'(FLOOR_LEN) + (TIME_W+1)'(speed_e) >= (TIME_W+1)'(ROUND_LEN)) begin
            round_len = FLOOR_LEN;
        end else begin
            round_len = ROUND_LEN - TIME_W'(speed_e);
        end
    end

    assign points    = PTS_W'(2) << exp_q;
    assign score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(points);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            choose_q   <= 1'b0;
            time_q     <= '0;
            round_q    <= '0;
            score_q    <= '0;
            lives_q    <= LIVES_INIT;
            pass_mod_q <= '0;
            exp_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            choose_q   <= choose_d;
            time_q     <= time_d;
            round_q    <= round_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            pass_mod_q <= pass_mod_d;
            exp_q      <= exp_d;
            start_q    <= start_d;
        end
    end

    // Next-state and registered-output logic; choose_d is high exactly on entry to PROMPT.
    always_comb begin
        state_d    = state_q;
        choose_d   = 1'b0;
        time_d     = time_q;
        round_d    = round_q;
        score_d    = score_q;
        lives_d    = lives_q;
        pass_mod_d = pass_mod_q;
        exp_d      = exp_q;
        start_d    = start;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                time_d = '0;
                if (start_rise) begin
                    round_d    = '0;
                    score_d    = '0;
                    lives_d    = LIVES_INIT;
                    pass_mod_d = '0;
                    exp_d      = '0;
                    choose_d   = 1'b1;
                    state_d    = ST_PROMPT;
                end
            end

            ST_PROMPT: begin
                time_d  = round_len;
                state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (check_valid) begin
                    state_d = is_correct ? ST_PASS : ST_FAIL;
                end else if (tick_1hz) begin
                    if (time_q == TIME_W'(1)) begin
                        time_d  = '0;
                        state_d = ST_FAIL;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end

            ST_PASS: begin
                score_d = (score_sum >= (SCORE_W+1)'(SCORE_MAX)) ? SCORE_MAX
                                                                : score_sum[SCORE_W-1:0];
                if (round_q != ROUND_MAX) begin
                    round_d = round_q + ROUND_W'(1);
                end
                // Every fifth pass bumps the points exponent.
                if (pass_mod_q == MOD_LAST) begin
                    pass_mod_d = '0;
                    if (exp_q != EXP_MAX) begin
                        exp_d = exp_q + EXP_W'(1);
                    end
                end else begin
                    pass_mod_d = pass_mod_q + MOD_W'(1);
                end
                time_d  = BREAK_LEN;
                state_d = ST_BREAK;
            end

            ST_FAIL: begin
                lives_d = lives_q - LIVES_W'(1);
                if (lives_q == LIVES_W'(1)) begin
                    time_d  = '0;
                    state_d = ST_OVER;
                end else begin
                    time_d  = BREAK_LEN;
                    state_d = ST_BREAK;
                end
            end

            ST_BREAK: begin
                if (tick_1hz) begin
                    if (time_q == TIME_W'(1)) begin
                        time_d   = '0;
                        choose_d = 1'b1;
                        state_d  = ST_PROMPT;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end

            default: begin
                time_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign choose_flag  = choose_q;
    assign state        = 3'(state_q);
    assign time_left    = time_q;
    assign round_cnt    = round_q;
    assign score        = score_q;
    assign lives_left   = lives_q;
    assign round_active = (state_q == ST_PLAY);
    assign game_over    = (state_q == ST_OVER);

endmodule

// File: tb/tb_switch_game_round_ctrl.sv
// Self-checking bench for switch_game_round_ctrl: directed vector table, hand-written
// game sequences and randomized play against a game-rule reference model.
module tb_switch_game_round_ctrl;

    localparam int ROUND_SECS     = 15;
    localparam int BREAK_SECS     = 5;
    localparam int LIVES          = 3;
    localparam int MIN_ROUND_SECS = 5;

    localparam int S_IDLE = 0, S_PROMPT = 1, S_PLAY = 2, S_PASS = 3,
                   S_FAIL = 4, S_BREAK = 5, S_OVER = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        start = 1'b0;
    logic        check_valid = 1'b0;
    logic        is_correct = 1'b0;
    logic        choose_flag;
    logic [2:0]  state;
    logic [5:0]  time_left;
    logic [7:0]  round_cnt;
    logic [13:0] score;
    logic [1:0]  lives_left;
    logic        round_active;
    logic        game_over;

    switch_game_round_ctrl #(
        .ROUND_SECS    (ROUND_SECS),
        .BREAK_SECS    (BREAK_SECS),
        .LIVES         (LIVES),
        .MIN_ROUND_SECS(MIN_ROUND_SECS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_1hz    (tick_1hz),
        .start       (start),
        .check_valid (check_valid),
        .is_correct  (is_correct),
        .choose_flag (choose_flag),
        .state       (state),
        .time_left   (time_left),
        .round_cnt   (round_cnt),
        .score       (score),
        .lives_left  (lives_left),
        .round_active(round_active),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: game quantities kept as plain integers.
    int m_state, m_time, m_round, m_score, m_lives, m_passes;
    bit m_choose, m_start_prev;

    function automatic int exp_of(input int passes);
        int e;
        e = passes / 5;
        return (e > 6) ? 6 : e;
    endfunction

    function automatic int round_len(input int passes);
        int l;
`ifdef SWITCH_GAME_SPEEDUP_EN
        l = ROUND_SECS - exp_of(passes);
        if (l < MIN_ROUND_SECS) l = MIN_ROUND_SECS;
`else
        l = ROUND_SECS;
`endif
        return l;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_time = 0; m_round = 0; m_score = 0;
        m_lives = LIVES; m_passes = 0; m_choose = 0; m_start_prev = 0;
    endtask

    task automatic model_clk(input bit s, input bit tk, input bit cv, input bit ic);
        bit rise;
        rise = s && !m_start_prev;
        m_start_prev = s;
        m_choose = 0;
        case (m_state)
            S_IDLE, S_OVER: begin
                m_time = 0;
                if (rise) begin
                    m_score = 0; m_round = 0; m_lives = LIVES; m_passes = 0;
                    m_state = S_PROMPT; m_choose = 1;
                end
            end
            S_PROMPT: begin
                m_time = round_len(m_passes);
                m_state = S_PLAY;
            end
            S_PLAY: begin
                if (cv) m_state = ic ? S_PASS : S_FAIL;
                else if (tk) begin
                    if (m_time == 1) begin m_time = 0; m_state = S_FAIL; end
                    else m_time = m_time - 1;
                end
            end
            S_PASS: begin
                m_score = m_score + (2 << exp_of(m_passes));
                if (m_score > 9999) m_score = 9999;
                m_passes = m_passes + 1;
                if (m_round < 255) m_round = m_round + 1;
                m_time = BREAK_SECS;
                m_state = S_BREAK;
            end
            S_FAIL: begin
                m_lives = m_lives - 1;
                if (m_lives == 0) begin m_time = 0; m_state = S_OVER; end
                else begin m_time = BREAK_SECS; m_state = S_BREAK; end
            end
            S_BREAK: begin
                if (tk) begin
                    if (m_time == 1) begin m_time = 0; m_state = S_PROMPT; m_choose = 1; end
                    else m_time = m_time - 1;
                end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"},        int'(state),        m_state);
        chk({tag, ".time_left"},    int'(time_left),    m_time);
        chk({tag, ".round_cnt"},    int'(round_cnt),    m_round);
        chk({tag, ".score"},        int'(score),        m_score);
        chk({tag, ".lives_left"},   int'(lives_left),   m_lives);
        chk({tag, ".choose_flag"},  int'(choose_flag),  int'(m_choose));
        chk({tag, ".round_active"}, int'(round_active), (m_state == S_PLAY) ? 1 : 0);
        chk({tag, ".game_over"},    int'(game_over),    (m_state == S_OVER) ? 1 : 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},        int'(state),        S_IDLE);
        chk({tag, ".choose_flag"},  int'(choose_flag),  0);
        chk({tag, ".time_left"},    int'(time_left),    0);
        chk({tag, ".round_cnt"},    int'(round_cnt),    0);
        chk({tag, ".score"},        int'(score),        0);
        chk({tag, ".lives_left"},   int'(lives_left),   LIVES);
        chk({tag, ".round_active"}, int'(round_active), 0);
        chk({tag, ".game_over"},    int'(game_over),    0);
    endtask

    task automatic step(input bit s, input bit tk, input bit cv, input bit ic, input string tag);
        start = s; tick_1hz = tk; check_valid = cv; is_correct = ic;
        @(posedge clk);
        model_clk(s, tk, cv, ic);
        #1;
        chk_model(tag);
    endtask

    task automatic do_reset(input string tag);
        start = 0; tick_1hz = 0; check_valid = 0; is_correct = 0;
        @(negedge clk);
        reset_n = 0;
        #1;
        chk_reset_vals(tag);
        model_reset();
        @(negedge clk);
        reset_n = 1;
    endtask

    typedef struct {
        bit s, tk, cv, ic;
        int st, tl, sc, lv;
        bit ch;
    } vec_t;

    vec_t vecs[16];

    initial begin
        //            s  tk cv ic  state     time sc lv ch
        vecs[0]  = '{0, 0, 0, 0, S_IDLE,   0,  0, 3, 0};
        vecs[1]  = '{1, 0, 0, 0, S_PROMPT, 0,  0, 3, 1};
        vecs[2]  = '{1, 0, 0, 0, S_PLAY,   15, 0, 3, 0};
        vecs[3]  = '{0, 1, 0, 0, S_PLAY,   14, 0, 3, 0};
        vecs[4]  = '{0, 0, 1, 1, S_PASS,   14, 0, 3, 0};
        vecs[5]  = '{0, 0, 0, 0, S_BREAK,  5,  2, 3, 0};
        vecs[6]  = '{0, 1, 0, 0, S_BREAK,  4,  2, 3, 0};
        vecs[7]  = '{0, 0, 1, 0, S_BREAK,  4,  2, 3, 0};
        vecs[8]  = '{1, 0, 0, 0, S_BREAK,  4,  2, 3, 0};
        vecs[9]  = '{0, 1, 0, 0, S_BREAK,  3,  2, 3, 0};
        vecs[10] = '{0, 1, 0, 0, S_BREAK,  2,  2, 3, 0};
        vecs[11] = '{0, 1, 0, 0, S_BREAK,  1,  2, 3, 0};
        vecs[12] = '{0, 1, 0, 0, S_PROMPT, 0,  2, 3, 1};
        vecs[13] = '{0, 1, 0, 0, S_PLAY,   15, 2, 3, 0};
        vecs[14] = '{0, 0, 1, 0, S_FAIL,   15, 2, 3, 0};
        vecs[15] = '{0, 0, 0, 0, S_BREAK,  5,  2, 2, 0};

        do_reset("rst0");

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].s; tick_1hz = vecs[i].tk;
            check_valid = vecs[i].cv; is_correct = vecs[i].ic;
            @(posedge clk);
            model_clk(vecs[i].s, vecs[i].tk, vecs[i].cv, vecs[i].ic);
            #1;
            chk($sformatf("vec%0d.state", i),  int'(state),       vecs[i].st);
            chk($sformatf("vec%0d.time", i),   int'(time_left),   vecs[i].tl);
            chk($sformatf("vec%0d.score", i),  int'(score),       vecs[i].sc);
            chk($sformatf("vec%0d.lives", i),  int'(lives_left),  vecs[i].lv);
            chk($sformatf("vec%0d.choose", i), int'(choose_flag), int'(vecs[i].ch));
        end

        // Timeout round, then break, then the next prompt.
        do_reset("rst_a");
        step(1, 0, 0, 0, "a.start");
        chk("a.choose_hi", int'(choose_flag), 1);
        step(0, 0, 0, 0, "a.play");
        chk("a.choose_lo", int'(choose_flag), 0);
        chk("a.play_time", int'(time_left), 15);
        for (int i = 1; i <= 14; i++) begin
            step(0, 1, 0, 0, "a.count");
            chk("a.count_time", int'(time_left), 15 - i);
        end
        step(0, 1, 0, 0, "a.expire");
        chk("a.expire_state", int'(state), S_FAIL);
        step(0, 0, 0, 0, "a.break");
        chk("a.break_time", int'(time_left), 5);
        chk("a.break_lives", int'(lives_left), 2);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "a.brk");
        chk("a.reprompt_choose", int'(choose_flag), 1);
        chk("a.reprompt_state", int'(state), S_PROMPT);

        // Twelve correct rounds, exponent stepping.
        do_reset("rst_b");
        step(1, 0, 0, 0, "b.start");
        for (int r = 1; r <= 12; r++) begin
            step(0, 0, 0, 0, "b.play");
            if (r == 12) begin
`ifdef SWITCH_GAME_SPEEDUP_EN
                chk("b.r12_time", int'(time_left), 13);
`else
                chk("b.r12_time", int'(time_left), 15);
`endif
            end
            step(0, 0, 1, 1, "b.pass");
            step(0, 0, 0, 0, "b.break");
            for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "b.brk");
        end
        chk("b.score46", int'(score), 46);
        chk("b.rounds12", int'(round_cnt), 12);

        // Three wrong checks to game over, then restart.
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, "c.play");
            step(0, 0, 1, 0, "c.fail");
            step(0, 0, 0, 0, "c.after");
            if (k < 3) for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "c.brk");
        end
        chk("c.over_state", int'(state), S_OVER);
        chk("c.game_over", int'(game_over), 1);
        chk("c.score_held", int'(score), 46);
        step(0, 1, 0, 0, "c.hold");
        chk("c.score_held2", int'(score), 46);
        step(1, 0, 0, 0, "c.restart");
        chk("c.restart_state", int'(state), S_PROMPT);
        chk("c.restart_score", int'(score), 0);
        chk("c.restart_lives", int'(lives_left), 3);

        // Correct check coinciding with the expiring tick.
        step(0, 0, 0, 0, "d.play");
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, "d.count");
        chk("d.time1", int'(time_left), 1);
        step(0, 1, 1, 1, "d.coinc");
        chk("d.pass_state", int'(state), S_PASS);
        step(0, 0, 0, 0, "d.break");
        chk("d.score2", int'(score), 2);
        chk("d.lives3", int'(lives_left), 3);

        // Asynchronous reset in the middle of a round.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "e.brk");
        step(0, 0, 0, 0, "e.play");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, "e.count");
        chk("e.time7", int'(time_left), 7);
        #2;
        reset_n = 0;
        #1;
        chk_reset_vals("e.async");
        model_reset();
        @(negedge clk);
        reset_n = 1;
        step(0, 0, 0, 0, "e.idle");

        // Long winning streak to reach score saturation.
        do_reset("rst_f");
        step(1, 0, 0, 0, "f.start");
        for (int r = 0; r < 110; r++) begin
            step(0, 0, 0, 0, "f.play");
            step(0, 0, 1, 1, "f.pass");
            step(0, 0, 0, 0, "f.break");
            for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "f.brk");
        end
        chk("f.score_sat", int'(score), 9999);
        chk("f.rounds110", int'(round_cnt), 110);

        // Randomized play against the model.
        do_reset("rst_r");
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
